// File: rtl/comp_unit_pkg.sv
// Shared definitions for CompUnit and its upstream sequencer:
// CompUnit instruction codes and the sequencer state encoding.
package comp_unit_pkg;

  localparam logic [2:0] CLR    = 3'b000;
  localparam logic [2:0] HOLD   = 3'b001;
  localparam logic [2:0] BIAS   = 3'b101;
  localparam logic [2:0] MAC_L2 = 3'b110;
  localparam logic [2:0] MAC2   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_BIAS   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_OUTPUT = 3'd5
  } seq_state_e;

endpackage

// File: rtl/comp_unit_sequencer.sv
// Job sequencer for CompUnit: turns a dot-product job plus an operand stream
// into CompUnit instructions and returns the accumulated out1 as the result.
module comp_unit_sequencer
  import comp_unit_pkg::*;
#(
  parameter int VALUE_WIDTH = 16,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   cfg_len,
  input  logic                   cfg_bias_en,
  input  logic [VALUE_WIDTH-1:0] cfg_bias,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VALUE_WIDTH-1:0] in_a1,
  input  logic [VALUE_WIDTH-1:0] in_w1,
  input  logic [VALUE_WIDTH-1:0] in_a2,
  input  logic [VALUE_WIDTH-1:0] in_w2,
  output logic [2:0]             cu_instr,
  output logic [VALUE_WIDTH-1:0] cu_a1,
  output logic [VALUE_WIDTH-1:0] cu_w1,
  output logic [VALUE_WIDTH-1:0] cu_a2,
  output logic [VALUE_WIDTH-1:0] cu_w2,
  input  logic [VALUE_WIDTH-1:0] cu_out1,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [VALUE_WIDTH-1:0] res_data
);

  localparam logic [VALUE_WIDTH-1:0] VAL_ZERO = {VALUE_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]   LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]   LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  seq_state_e             state_r;
  seq_state_e             state_s;
  logic [LEN_WIDTH-1:0]   len_r;
  logic                   bias_en_r;
  logic [VALUE_WIDTH-1:0] bias_r;
  logic [LEN_WIDTH-1:0]   beats_left_r;
  logic                   odd_r;
  logic [VALUE_WIDTH-1:0] res_data_r;
  logic [LEN_WIDTH-1:0]   beats_total_s;
  logic                   last_beat_s;

  // ceil(len/2) without needing an extra carry bit
  assign beats_total_s = {1'b0, len_r[LEN_WIDTH-1:1]} + {{(LEN_WIDTH-1){1'b0}}, len_r[0]};
  assign last_beat_s   = (beats_left_r == LEN_ONE);

  assign busy      = (state_r != ST_IDLE);
  assign res_valid = (state_r == ST_OUTPUT);
  assign res_data  = res_data_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job configuration, beat counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r        <= LEN_ZERO;
      bias_en_r    <= 1'b0;
      bias_r       <= VAL_ZERO;
      beats_left_r <= LEN_ZERO;
      odd_r        <= 1'b0;
      res_data_r   <= VAL_ZERO;
    end else begin
      if ((state_r == ST_IDLE) && start) begin
        len_r     <= cfg_len;
        bias_en_r <= cfg_bias_en;
        bias_r    <= cfg_bias;
      end
      if (state_r == ST_CLEAR) begin
        beats_left_r <= beats_total_s;
        odd_r        <= len_r[0];
      end else if ((state_r == ST_STREAM) && in_valid && (beats_left_r != LEN_ZERO)) begin
        beats_left_r <= beats_left_r - LEN_ONE;
      end
      if (state_r == ST_DRAIN) begin
        res_data_r <= cu_out1;
      end
    end
  end

  // Next state, CompUnit instruction/operands and stream handshake
  always_comb begin
    state_s  = state_r;
    cu_instr = HOLD;
    cu_a1    = VAL_ZERO;
    cu_w1    = VAL_ZERO;
    cu_a2    = VAL_ZERO;
    cu_w2    = VAL_ZERO;
    in_ready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cu_instr = CLR;
        if (len_r != LEN_ZERO) begin
          state_s = ST_STREAM;
        end else if (bias_en_r) begin
          state_s = ST_BIAS;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_STREAM: begin
        in_ready = 1'b1;
        if (in_valid && last_beat_s && odd_r) begin
          // odd tail: lane 1 rides on CompUnit lane 2, lane 2 of the beat is dropped
          cu_instr = MAC_L2;
          cu_a2    = in_a1;
          cu_w2    = in_w1;
        end else begin
          cu_instr = in_valid ? MAC2 : HOLD;
          cu_a1    = in_a1;
          cu_w1    = in_w1;
          cu_a2    = in_a2;
          cu_w2    = in_w2;
        end
        if (in_valid && last_beat_s) begin
          state_s = bias_en_r ? ST_BIAS : ST_DRAIN;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_BIAS: begin
        cu_instr = BIAS;
        cu_w1    = bias_r;
        state_s  = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_s = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (res_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUTPUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/comp_unit_sequencer.md
Name: comp_unit_sequencer

Overview:
Upstream controller for CompUnit. It accepts a dot-product job (length, optional bias) and consumes a valid/ready stream of operand beats, each carrying two activation/weight pairs. It drives CompUnit's instr/A1/A2/W1/W2 each cycle, issuing clear, dual-MAC, single-lane tail MAC, bias-add and hold codes. It then captures CompUnit's out1 as the job result on a valid/ready output.

Parameters:
VALUE_WIDTH, 16, width of activations, weights, bias and result (matches CompUnit value_width)
LEN_WIDTH, 8, width of job element count

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  job request; sampled only in IDLE
cfg_len  in  LEN_WIDTH  number of elements (pairs a*w) in the job; 0 allowed
cfg_bias_en  in  1  add bias after the last MAC
cfg_bias  in  VALUE_WIDTH  bias value
busy  out  1  high whenever state != IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid&in_ready
in_a1, in_w1, in_a2, in_w2  in  VALUE_WIDTH each  beat lanes 1 and 2
cu_instr  out  3  CompUnit instr
cu_a1, cu_w1, cu_a2, cu_w2  out  VALUE_WIDTH each  CompUnit operands
cu_out1  in  VALUE_WIDTH  CompUnit out1 (registered, 1-cycle latency)
res_valid  out  1  result valid
res_ready  in  1  result consumed when res_valid&res_ready
res_data  out  VALUE_WIDTH  accumulated result

Behaviour:
- Instr codes: CLR=000 (out1<=0), MAC2=111 (out1<=out1+A1*W1+A2*W2), MAC_L2=110 (out1<=out1+A2*W2), BIAS=101 (out1<=out1+W1+W2), HOLD=001 (out1<=out1). HOLD must be 001. Codes 010/011/100 are forbidden: 100 doubles out1.
- Arithmetic wraps modulo 2^VALUE_WIDTH (CompUnit truncation). The sequencer does no arithmetic of its own.
- States: IDLE, CLEAR, STREAM, BIAS, DRAIN, OUTPUT.
- IDLE: cu_instr=HOLD, operands 0. On start, latch cfg_len, cfg_bias_en and cfg_bias, then go to CLEAR.
- CLEAR (1 cycle): cu_instr=CLR. Set beats_left=ceil(len/2) and odd=len[0]. If beats_left==0, go to BIAS when bias_en, else DRAIN. Otherwise go to STREAM.
- STREAM: in_ready=1. cu_a*/cu_w* are combinational from the in_* lanes.
  - Handshake on a non-final beat, or on the final beat when len is even: cu_instr=MAC2.
  - Final beat with odd len: lane 1 of the beat is routed to cu_a2/cu_w2, cu_a1/cu_w1=0, cu_instr=MAC_L2. Lane 2 of the beat is ignored.
  - in_valid low: cu_instr=HOLD, no counter change.
  - After the final handshake, go to BIAS when bias_en, else DRAIN.
- BIAS (1 cycle): cu_instr=BIAS, cu_w1=bias, cu_w2=0, cu_a*=0. Then go to DRAIN.
- DRAIN (1 cycle): cu_instr=HOLD. cu_out1 now holds the final sum; register it into res_data. Then go to OUTPUT.
- OUTPUT: res_valid=1, cu_instr=HOLD. On res_ready, clear res_valid and go to IDLE. No new job is accepted in the same cycle.
- in_ready is 0 in every state except STREAM. Beats offered outside STREAM are not consumed.
- start is ignored while busy. cfg_* changes after start have no effect on the running job.
- Latency (no stalls): start at cycle 0 → CLEAR at cycle 1 → beats at cycles 2..1+B → optional BIAS → DRAIN → res_valid in the next cycle.
  - len=4, no bias: res_valid first high at cycle 5.
- Reset values: state=IDLE, busy=0, in_ready=0, res_valid=0, res_data=0, beats_left=0, cu_instr=HOLD, cu operands 0.
- Reset mid-job aborts immediately with no result. CompUnit's stale out1 is harmless because every job begins with CLR.
- cu_instr must never be X in any state, including directly out of reset.

Decomposition:
- Shared package comp_unit_pkg holds the instr localparams CLR, MAC2, MAC_L2, BIAS and HOLD, and the state encoding. CompUnit and the sequencer both use it.
- No sub-module: one FSM plus a beat counter is the natural size.

Test Plan:
- len=4, beats (1,2,3,4) and (5,6,7,8), no stalls, no bias, res_ready=1 → instr sequence 000,111,111,001. res_data=1*2+3*4+5*6+7*8=100, res_valid at cycle 5.
- len=3, beats (2,3,4,5) and (6,7,9,9), bias_en=1, bias=10 → final beat issues 110 with cu_a2=6, cu_w2=7. Then 101 with W1=10. res_data=6+20+42+10=78.
- len=4 with in_valid low for 3 cycles between beats → cu_instr=001 during the gap, in_ready stays 1, res_data=100, res_valid 3 cycles later than the unstalled case.
- len=0, bias_en=1, bias=0x1234 → no beat consumed (in_ready never 1), res_data=0x1234. len=0 without bias → res_data=0.
- Overflow: len=2, beat (0xFFFF,0xFFFF,0,0) → res_data=0x0001 (wrap). Then hold res_ready=0 for 5 cycles: res_valid and res_data stable, start pulses ignored, busy=1.
- Assert rst during STREAM of a len=4 job, then run a new len=2 job with beat (3,3,0,0) → res_data=9, showing no carry-over from the aborted job.
